aes_sbox_dom_sched: RTL and testbench
=====================================

Name: aes_sbox_dom_sched

Overview:
- Sequences byte substitutions through one shared, pipelined, d-share DOM AES S-box (fixed latency LAT, no stall input) for one AES round.
- Arbitrates between two requesters: the 4 key-schedule bytes and the 16 state bytes.
- Gates every issue on availability of fresh randomness.
- Returns each result tagged with its byte index, so the surrounding datapath can mux S-box inputs and write back outputs.

Parameters:
- LAT, 5, S-box pipeline latency in cycles from input-register to output (>=1).
- NSTATE, 16, number of state bytes per round.
- NKEY, 4, number of key-schedule bytes per round.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse to begin a round; sampled only in IDLE.
- key_en  input  1  sampled with start; 1 = include the key bytes this round.
- rnd_valid  input  1  fresh-randomness buses for the S-box are valid this cycle.
- rnd_ready  output  1  randomness consumed this cycle (equals issue_valid).
- issue_valid  output  1  S-box input is registered this cycle.
- issue_idx  output  5  byte being issued: 0..15 are state bytes, 16..19 are key bytes.
- res_valid  output  1  S-box output is valid for res_idx.
- res_idx  output  5  index of the result byte.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the round is complete.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, all tag-pipeline valid bits 0.
- Asynchronous reset mid-round: aborts the round immediately. No res_valid may appear afterwards for bytes issued before reset.

States:
- IDLE: on start, latch key_en, clear the issue and result counters, go to ISSUE. busy rises the next cycle.
- ISSUE: issue_valid = rnd_valid.
  - Each issue advances the byte pointer.
  - Order when key_en=1: 16,17,18,19, then 0..15. Key bytes have fixed priority.
  - Order when key_en=0: 0..15 only.
  - After the last issue, go to DRAIN.
- DRAIN: no issues. When the final result's res_valid has been asserted, go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
  - start in DONE is ignored.

Issue, stall and result rules:
- rnd_valid=0 in ISSUE inserts a bubble: issue_valid=0 and the pointer holds. The S-box pipeline keeps running.
- Tag pipeline: a LAT-deep shift register of {valid, idx}, shifted every cycle.
  - An issue at cycle t produces res_valid=1 and res_idx=issue_idx exactly at cycle t+LAT.
  - Results emerge in issue order, with the same bubble pattern as the issues.
- Completion counter: counts res_valid. The last result is the NKEY+NSTATE-th (or NSTATE-th) result.
  - done is asserted in the cycle after that last res_valid.
  - LAT=1 is legal: DRAIN can last one cycle.
- start while busy, or in DONE: ignored, with no effect on counters.
- Minimum round length with no bubbles, measured from start to done:
  - key_en=1: 1 + 20 + LAT cycles.
  - key_en=0: 1 + 16 + LAT cycles.
- issue_idx holds its last value when issue_valid=0. Its value then is don't-care but must be stable, to avoid glitching the share muxes.
- Counter widths: 5-bit pointer; saturating tag pipeline, no wrap.

Test Plan:
- Reset with LAT=5. Pulse start with key_en=1 and hold rnd_valid=1.
  - issue_idx sequence must be 16,17,18,19,0..15 on 20 consecutive cycles starting 1 cycle after start.
  - res_idx must show the same sequence 5 cycles later.
  - done must pulse 26 cycles after start.
- Pulse start with key_en=0 and hold rnd_valid=1.
  - Exactly 16 issues, 0..15.
  - done must pulse 22 cycles after start.
  - res_idx 16..19 must never appear.
- key_en=1 with rnd_valid toggled 1,0,1,0,… during ISSUE.
  - Issues occur only on rnd_valid=1 cycles, and rnd_ready equals issue_valid.
  - res_valid reproduces the bubble pattern delayed by 5 cycles.
  - Exactly 20 results before done.
- Pulse start again at ISSUE cycle 3 and again in DONE.
  - The issue sequence is unchanged and exactly one done pulse occurs.
- Assert rst at 8 cycles after start, while bytes are in flight.
  - All outputs go to 0 immediately.
  - No res_valid appears for the next 10 cycles.
  - A fresh start then completes normally with 20 results.
- Rebuild with LAT=1, key_en=0, rnd_valid=1.
  - Each res_valid follows its issue by 1 cycle.
  - done pulses 18 cycles after start.

Source files
------------

// File: rtl/aes_sbox_dom_sched_if.sv
// aes_sbox_dom_sched_if: start/randomness/issue/result bus of the shared DOM S-box scheduler
interface aes_sbox_dom_sched_if;
  logic       start;
  logic       key_en;
  logic       rnd_valid;
  logic       rnd_ready;
  logic       issue_valid;
  logic [4:0] issue_idx;
  logic       res_valid;
  logic [4:0] res_idx;
  logic       busy;
  logic       done;
  modport master (
    output start, key_en, rnd_valid,
    input  rnd_ready, issue_valid, issue_idx, res_valid, res_idx, busy, done
  );
  modport slave (
    input  start, key_en, rnd_valid,
    output rnd_ready, issue_valid, issue_idx, res_valid, res_idx, busy, done
  );
endinterface

// File: rtl/aes_sbox_dom_sched.sv
// aes_sbox_dom_sched: issues key/state bytes to a LAT-deep DOM S-box, gated on fresh randomness, and tags results
module aes_sbox_dom_sched #(
  parameter int LAT    = 5,
  parameter int NSTATE = 16,
  parameter int NKEY   = 4
) (
  input logic                  clk,
  input logic                  rst,
  aes_sbox_dom_sched_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0]     st_q, st_d;
  logic           key_q;
  logic [4:0]     idx_q, iss_q, res_q;
  logic [LAT-1:0] tv_q;
  logic [4:0]     ti_q [LAT];
  logic           issue, go;
  logic [4:0]     total;
  assign go    = st_q == IDLE && bus.start;
  assign issue = st_q == ISSUE && bus.rnd_valid;
  assign total = key_q ? 5'(NSTATE + NKEY) : 5'(NSTATE);
  always_comb
    st_d = go                                                        ? ISSUE :
           (issue && iss_q == total - 5'd1)                          ? DRAIN :
           (st_q == DRAIN && bus.res_valid && res_q == total - 5'd1) ? DONE  :
           (st_q == DONE)                                            ? IDLE  : st_q;
  // idx_q always holds the next byte to issue, so issue_idx is a clean register output
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q  <= IDLE;
      key_q <= 1'b0;
      idx_q <= '0;
      iss_q <= '0;
      res_q <= '0;
      tv_q  <= '0;
      for (int i = 0; i < LAT; i++) ti_q[i] <= '0;
    end else begin
      st_q <= st_d;
      if (go) begin
        key_q <= bus.key_en;
        idx_q <= bus.key_en ? 5'(NSTATE) : 5'd0;
        iss_q <= '0;
        res_q <= '0;
      end else begin
        if (issue) begin
          iss_q <= iss_q + 5'd1;
          idx_q <= idx_q == 5'(NSTATE + NKEY - 1) ? 5'd0 : idx_q + 5'd1;
        end
        if (bus.res_valid) res_q <= res_q + 5'd1;
      end
      for (int i = LAT - 1; i > 0; i--) begin
        tv_q[i] <= tv_q[i-1];
        ti_q[i] <= ti_q[i-1];
      end
      tv_q[0] <= issue;
      ti_q[0] <= idx_q;
    end
  assign bus.issue_valid = issue;
  assign bus.rnd_ready   = issue;
  assign bus.issue_idx   = idx_q;
  assign bus.res_valid   = tv_q[LAT-1];
  assign bus.res_idx     = ti_q[LAT-1];
  assign bus.busy        = st_q == ISSUE || st_q == DRAIN;
  assign bus.done        = st_q == DONE;
endmodule

// File: tb/tb_aes_sbox_dom_sched.sv
// tb_aes_sbox_dom_sched: checks the scheduler with LAT=5 and LAT=1 against a cycle-indexed issue/result model
module tb_aes_sbox_dom_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, key_en = 1'b0, rv = 1'b0, sel = 1'b0;
  int   cmp = 0, mis = 0;
  always #5 clk = ~clk;
  aes_sbox_dom_sched_if ifa ();
  aes_sbox_dom_sched_if ifb ();
  assign ifa.start     = !sel && start;
  assign ifa.key_en    = key_en;
  assign ifa.rnd_valid = rv;
  assign ifb.start     = sel && start;
  assign ifb.key_en    = key_en;
  assign ifb.rnd_valid = rv;
  aes_sbox_dom_sched #(.LAT(5)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  aes_sbox_dom_sched #(.LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  logic       o_iv, o_rr, o_rv, o_busy, o_done;
  logic [4:0] o_ii, o_ri;
  assign o_iv   = sel ? ifb.issue_valid : ifa.issue_valid;
  assign o_rr   = sel ? ifb.rnd_ready   : ifa.rnd_ready;
  assign o_ii   = sel ? ifb.issue_idx   : ifa.issue_idx;
  assign o_rv   = sel ? ifb.res_valid   : ifa.res_valid;
  assign o_ri   = sel ? ifb.res_idx     : ifa.res_idx;
  assign o_busy = sel ? ifb.busy        : ifa.busy;
  assign o_done = sel ? ifb.done        : ifa.done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    cmp++;
    assert (obs === exp_v) else begin
      mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic s);
    @(posedge clk);
    #1 rv = r;
    start = s;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_iv"}, 32'(o_iv), 0);
    chk({tag, "_rr"}, 32'(o_rr), 0);
    chk({tag, "_ii"}, 32'(o_ii), 0);
    chk({tag, "_rv"}, 32'(o_rv), 0);
    chk({tag, "_ri"}, 32'(o_ri), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
  endtask

  // mode 0: randomness always valid, 1: alternating 1,0,..., 2: random
  task automatic round(input logic ke, input int mode, input bit restart, input int abort_at);
    int   order[$];
    bit   hv[256];
    int   hi[256];
    int   lat, n_tot, k, r, done_cyc;
    logic r_in, st, exp_iv, exp_rv, exp_done;
    bit   fin, aborted;
    lat = sel ? 1 : 5;
    n_tot = ke ? 20 : 16;
    if (ke) for (int i = 16; i < 20; i++) order.push_back(i);
    for (int i = 0; i < 16; i++) order.push_back(i);
    for (int i = 0; i < 256; i++) begin hv[i] = 0; hi[i] = 0; end
    k = 0; r = 0; done_cyc = -1; fin = 0; aborted = 0;
    key_en = ke;
    step(1'($urandom_range(0, 1)), 1'b1);
    chk("idle_busy", 32'(o_busy), 0);
    chk("idle_iv", 32'(o_iv), 0);
    for (int n = 1; n < 200 && !fin && !aborted; n++) begin
      r_in = (k >= n_tot || mode == 2) ? 1'($urandom_range(0, 1)) : mode == 0 ? 1'b1 : 1'(n % 2);
      st = restart && (n == 3 || n == done_cyc);
      step(r_in, st);
      exp_iv = k < n_tot && r_in;
      chk("issue_valid", 32'(o_iv), 32'(exp_iv));
      chk("rnd_ready", 32'(o_rr), 32'(exp_iv));
      if (exp_iv) begin
        chk("issue_idx", 32'(o_ii), 32'(order[k]));
        hv[n] = 1; hi[n] = order[k]; k++;
      end
      exp_rv = n > lat && hv[n-lat];
      chk("res_valid", 32'(o_rv), 32'(exp_rv));
      if (exp_rv) begin
        chk("res_idx", 32'(o_ri), 32'(hi[n-lat]));
        r++;
      end
      exp_done = n == done_cyc;
      chk("done", 32'(o_done), 32'(exp_done));
      chk("busy", 32'(o_busy), 32'(!exp_done));
      if (exp_done) fin = 1;
      if (exp_rv && r == n_tot) done_cyc = n + 1;
      if (n == abort_at) aborted = 1;
    end
    if (!aborted) begin
      if (!fin) chk("round_timeout", 0, 1);
      step(1'b1, 1'b0);
      chk("post_done", 32'(o_done), 0);
      chk("post_busy", 32'(o_busy), 0);
      chk("post_iv", 32'(o_iv), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    round(1'b1, 0, 0, -1);
    round(1'b0, 0, 0, -1);
    round(1'b1, 1, 0, -1);
    round(1'b1, 2, 0, -1);
    round(1'b0, 2, 0, -1);
    round(1'b1, 0, 1, -1);
    round(1'b1, 0, 0, 8);
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      chk("after_rst_rv", 32'(o_rv), 0);
      chk("after_rst_iv", 32'(o_iv), 0);
    end
    round(1'b1, 0, 0, -1);
    sel = 1'b1;
    round(1'b0, 0, 0, -1);
    round(1'b1, 2, 0, -1);
    round(1'b1, 1, 1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
